// File: rtl/ram_dp_sr_sw_be_if.sv
// ram_dp_sr_sw_be_if: one RAM access port (request in, read data and valid strobe out)
// Signals: cs (request), we (1 = write), be (write byte lanes), address (word address),
//          wdata (write data), rdata (read data, held between strobes), rvalid (one-cycle read strobe)
interface ram_dp_sr_sw_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic                  cs;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  modport master (output cs, we, be, address, wdata, input rdata, rvalid);
  modport slave  (input cs, we, be, address, wdata, output rdata, rvalid);
endinterface

// File: rtl/ram_dp_sr_sw_be.sv
// ram_dp_sr_sw_be: true dual-port byte-enable RAM with zero-fill after reset, 1/2-cycle read latency and collision tracking
// Ports: clk, reset_n (async active-low); port_0 / port_1 access ports (port 0 wins same-address write lanes);
//        o_init_done (zero-fill complete, ports ignored while low), o_collision (registered same-address
//        dual-write pulse), o_collision_count (saturating count of collisions)
module ram_dp_sr_sw_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_dp_sr_sw_be_if.slave port_0,
  ram_dp_sr_sw_be_if.slave port_1,
  output logic             o_init_done,
  output logic             o_collision,
  output logic [15:0]      o_collision_count
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  typedef enum logic {S_INIT, S_READY} state_t;
  state_t                r_state, w_state_nxt;
  logic                  w_fill;
  logic [ADDR_WIDTH-1:0] r_fill_addr;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [1:0]            w_rd, w_wr, w_pipe_v, r_s1_v, r_rvalid;
  logic [ADDR_WIDTH-1:0] w_addr [2];
  logic [BE_WIDTH-1:0]   w_be [2];
  logic [DATA_WIDTH-1:0] w_wdata [2], w_mask [2], w_rword [2], w_pipe_d [2];
  logic [DATA_WIDTH-1:0] r_s1_d [2], r_rdata [2];
  logic                  w_coll, r_coll;
  logic [15:0]           r_coll_cnt;

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [BE_WIDTH-1:0] be);
    lane_mask = '0;
    for (int i = 0; i < BE_WIDTH; i++) lane_mask[8*i +: 8] = {8{be[i]}};
  endfunction

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state     <= S_INIT;
      r_fill_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill_addr <= w_fill ? r_fill_addr + 1'b1 : r_fill_addr;
    end

  always_comb w_state_nxt = (r_state == S_INIT && r_fill_addr == LAST) ? S_READY : r_state;

  always_comb begin
    w_fill      = r_state == S_INIT;
    o_init_done = r_state == S_READY;
  end

  assign w_addr[0]  = port_0.address;
  assign w_addr[1]  = port_1.address;
  assign w_be[0]    = port_0.be;
  assign w_be[1]    = port_1.be;
  assign w_wdata[0] = port_0.wdata;
  assign w_wdata[1] = port_1.wdata;
  assign w_rd       = {port_1.cs & ~port_1.we, port_0.cs & ~port_0.we} & {2{o_init_done}};
  assign w_wr       = {port_1.cs &  port_1.we, port_0.cs &  port_0.we} & {2{o_init_done}};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic w_hit;
    assign w_mask[p] = lane_mask(w_be[p]);
    // a reader never writes in the same cycle, so the only write that can overlap is the other port's
    assign w_hit       = w_wr[1-p] && w_addr[1-p] == w_addr[p];
    assign w_rword[p]  = (RDW_MODE != 0 && w_hit) ?
                         (r_mem[w_addr[p]] & ~w_mask[1-p]) | (w_wdata[1-p] & w_mask[1-p]) : r_mem[w_addr[p]];
    assign w_pipe_v[p] = READ_LATENCY == 2 ? r_s1_v[p] : w_rd[p];
    assign w_pipe_d[p] = READ_LATENCY == 2 ? r_s1_d[p] : w_rword[p];
  end

  // port 0 lanes are written last so they override port 1 on a shared address
  always_ff @(posedge clk) begin
    if (w_fill) r_mem[r_fill_addr] <= '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (w_wr[1] && w_be[1][i]) r_mem[w_addr[1]][8*i +: 8] <= w_wdata[1][8*i +: 8];
      if (w_wr[0] && w_be[0][i]) r_mem[w_addr[0]][8*i +: 8] <= w_wdata[0][8*i +: 8];
    end
  end

  assign w_coll = &w_wr && w_addr[0] == w_addr[1] && |w_be[0] && |w_be[1];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_s1_v     <= '0;
      r_rvalid   <= '0;
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
      for (int p = 0; p < 2; p++) begin
        r_s1_d[p]  <= '0;
        r_rdata[p] <= '0;
      end
    end else begin
      r_s1_v     <= w_rd;
      r_rvalid   <= w_pipe_v;
      r_coll     <= w_coll;
      r_coll_cnt <= r_coll_cnt + 16'(w_coll && r_coll_cnt != 16'hFFFF);
      for (int p = 0; p < 2; p++) begin
        r_s1_d[p]  <= w_rword[p];
        r_rdata[p] <= w_pipe_v[p] ? w_pipe_d[p] : r_rdata[p];
      end
    end

  assign port_0.rdata      = r_rdata[0];
  assign port_1.rdata      = r_rdata[1];
  assign port_0.rvalid     = r_rvalid[0];
  assign port_1.rvalid     = r_rvalid[1];
  assign o_collision       = r_coll;
  assign o_collision_count = r_coll_cnt;
endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// tb_ram_dp_sr_sw_be: directed bench for two configurations (latency 1 / old-data and latency 2 / new-data)
module tb_ram_dp_sr_sw_be;
  logic        clk = 0, reset_n = 0;
  logic        cs0 = 0, we0 = 0, cs1 = 0, we1 = 0;
  logic [3:0]  be0 = 0, be1 = 0;
  logic [7:0]  a0 = 0, a1 = 0;
  logic [31:0] wd0 = 0, wd1 = 0;
  logic [31:0] rd_0 [2], rd_1 [2];
  logic        rv_0 [2], rv_1 [2], done [2], coll [2];
  logic [15:0] cnt [2];
  int          total = 0, passed = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cfg%0d: got %h expected %h at %0t", name, c, act, exp, $time);
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] b);
    lanes = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int RL  = g + 1;
    localparam int RDW = g;
    ram_dp_sr_sw_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_0 ();
    ram_dp_sr_sw_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_1 ();
    assign bus_0.cs = cs0;
    assign bus_0.we = we0;
    assign bus_0.be = be0;
    assign bus_0.address = a0;
    assign bus_0.wdata = wd0;
    assign bus_1.cs = cs1;
    assign bus_1.we = we1;
    assign bus_1.be = be1;
    assign bus_1.address = a1;
    assign bus_1.wdata = wd1;
    assign rd_0[g] = bus_0.rdata;
    assign rd_1[g] = bus_1.rdata;
    assign rv_0[g] = bus_0.rvalid;
    assign rv_1[g] = bus_1.rvalid;

    ram_dp_sr_sw_be #(.READ_LATENCY(RL), .RDW_MODE(RDW)) dut (
      .clk(clk), .reset_n(reset_n), .port_0(bus_0), .port_1(bus_1),
      .o_init_done(done[g]), .o_collision(coll[g]), .o_collision_count(cnt[g]));

    logic [31:0] m_mem [256];
    logic [31:0] e_rd [2], p_d [2], nd [2], old0, old1, od;
    bit          e_rv [2], p_v [2], nv [2], e_coll, ready = 0, ov;
    int          fill = 0, e_cnt = 0;

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ready = 0; fill = 0; e_coll = 0; e_cnt = 0;
        for (int p = 0; p < 2; p++) begin e_rv[p] = 0; e_rd[p] = 0; p_v[p] = 0; p_d[p] = 0; end
      end else begin
        for (int p = 0; p < 2; p++) begin nv[p] = 0; nd[p] = 0; end
        e_coll = 0;
        if (!ready) begin
          fill++;
          if (fill == 256) begin
            ready = 1;
            for (int i = 0; i < 256; i++) m_mem[i] = 0;
          end
        end else begin
          old0 = m_mem[a0];
          old1 = m_mem[a1];
          if (cs1 && we1) m_mem[a1] = (m_mem[a1] & ~lanes(be1)) | (wd1 & lanes(be1));
          if (cs0 && we0) m_mem[a0] = (m_mem[a0] & ~lanes(be0)) | (wd0 & lanes(be0));
          e_coll = cs0 && we0 && cs1 && we1 && a0 == a1 && be0 != 0 && be1 != 0;
          if (e_coll && e_cnt < 65535) e_cnt++;
          nv[0] = cs0 && !we0;
          nd[0] = RDW ? m_mem[a0] : old0;
          nv[1] = cs1 && !we1;
          nd[1] = RDW ? m_mem[a1] : old1;
        end
        for (int p = 0; p < 2; p++) begin
          ov = RL == 1 ? nv[p] : p_v[p];
          od = RL == 1 ? nd[p] : p_d[p];
          p_v[p] = nv[p];
          p_d[p] = nd[p];
          e_rv[p] = ov;
          if (ov) e_rd[p] = od;
        end
      end
      #1;
      check("init_done", g, done[g], ready);
      check("rvalid_0", g, rv_0[g], e_rv[0]);
      check("rvalid_1", g, rv_1[g], e_rv[1]);
      check("rdata_0", g, rd_0[g], e_rd[0]);
      check("rdata_1", g, rd_1[g], e_rd[1]);
      check("collision", g, coll[g], e_coll);
      check("collision_count", g, cnt[g], e_cnt);
    end
  end

  task automatic set(input bit c0, input bit w0, input logic [3:0] b0, input logic [7:0] ad0, input logic [31:0] d0,
                     input bit c1, input bit w1, input logic [3:0] b1, input logic [7:0] ad1, input logic [31:0] d1);
    cs0 = c0; we0 = w0; be0 = b0; a0 = ad0; wd0 = d0;
    cs1 = c1; we1 = w1; be1 = b1; a1 = ad1; wd1 = d1;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n, stale;
    repeat (2) @(negedge clk);
    check("reset_done", 0, done[0], 0);
    check("reset_rvalid", 1, rv_1[1], 0);
    check("reset_rdata", 1, rd_0[1], 0);
    check("reset_count", 0, cnt[0], 0);
    reset_n = 1;
    n = 0;
    while (!done[0] && n < 400) begin @(posedge clk); #1; n++; end
    check("init_cycles", 0, n, 256);
    check("init_done_cfg1", 1, done[1], 1);

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      set(1, 0, 0, 8'(i), 0, 1, 0, 0, 8'(255 - i), 0);
    end
    @(negedge clk);
    check("readall_rv", 0, rv_0[0], 1);
    check("readall_data", 0, rd_1[0], 0);
    idle();

    @(negedge clk); set(1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    @(negedge clk); set(1, 1, 4'h1, 8'h10, 32'h000000AA, 0, 0, 0, 0, 0);
    @(negedge clk); set(0, 0, 0, 0, 0, 1, 0, 0, 8'h10, 0);
    @(negedge clk);
    check("be_merge_rv", 0, rv_1[0], 1);
    check("be_merge", 0, rd_1[0], 32'hDEADBEAA);
    idle();
    @(negedge clk);
    check("be_merge", 1, rd_1[1], 32'hDEADBEAA);

    set(1, 1, 4'h3, 8'h20, 32'h11111111, 1, 1, 4'hF, 8'h20, 32'h22222222);
    @(negedge clk);
    check("coll_pulse", 0, coll[0], 1);
    check("coll_pulse", 1, coll[1], 1);
    check("coll_count", 0, cnt[0], 1);
    idle();
    @(negedge clk);
    check("coll_one_pulse", 0, coll[0], 0);
    set(1, 0, 0, 8'h20, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("coll_word", 0, rd_0[0], 32'h22221111);
    idle();
    @(negedge clk);
    check("coll_word", 1, rd_0[1], 32'h22221111);

    set(1, 1, 4'hF, 8'h30, 32'h00000055, 1, 0, 0, 8'h30, 0);
    @(negedge clk);
    check("rdw_old_rv", 0, rv_1[0], 1);
    check("rdw_old", 0, rd_1[0], 32'h0);
    check("rdw_not_coll", 0, cnt[0], 1);
    idle();
    @(negedge clk);
    check("rdw_new_rv", 1, rv_1[1], 1);
    check("rdw_new", 1, rd_1[1], 32'h55);

    for (int i = 0; i < 4; i++) begin
      set(1, 1, 4'hF, 8'(i), 32'hA0 + i, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    for (int t = 0; t < 7; t++) begin
      if (t >= 1) begin
        check("burst_rv", 1, rv_1[1], t >= 2 && t <= 5);
        if (t >= 2 && t <= 5) check("burst_data", 1, rd_1[1], 32'hA0 + t - 2);
      end
      if (t < 4) set(0, 0, 0, 0, 0, 1, 0, 0, 8'(t), 0);
      else idle();
      @(negedge clk);
    end

    set(1, 0, 0, 8'h02, 0, 1, 0, 0, 8'h01, 0);
    @(negedge clk);
    check("inflight_not_yet", 1, rv_0[1], 0);
    idle();
    reset_n = 0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("rst_rv0", c, rv_0[c], 0);
      check("rst_rv1", c, rv_1[c], 0);
      check("rst_rd0", c, rd_0[c], 0);
      check("rst_rd1", c, rd_1[c], 0);
      check("rst_done", c, done[c], 0);
      check("rst_count", c, cnt[c], 0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1;
    n = 0;
    stale = 0;
    while (!done[0] && n < 400) begin
      @(negedge clk);
      if (n == 250) set(1, 1, 4'hF, 8'h05, 32'hFF, 1, 0, 0, 8'h05, 0);
      else idle();
      stale += int'(rv_0[0]) + int'(rv_1[0]) + int'(rv_0[1]) + int'(rv_1[1]);
      n++;
    end
    idle();
    check("no_stale_rvalid", 0, stale, 0);
    check("reinit_done", 0, done[0], 1);
    @(negedge clk);
    set(1, 0, 0, 8'h05, 0, 1, 0, 0, 8'h05, 0);
    @(negedge clk);
    check("init_write_dropped_rv", 0, rv_0[0], 1);
    check("init_write_dropped", 0, rd_0[0], 0);
    check("init_write_dropped", 0, rd_1[0], 0);
    idle();
    @(negedge clk);
    check("init_write_dropped_rv", 1, rv_1[1], 1);
    check("init_write_dropped", 1, rd_1[1], 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
